// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: fetches one byte of a register over a shared debug port
// and scans it onto a two-digit active-low seven-segment display.
`timescale 1ns/1ps

module seg_scan_ctrl #(
  parameter int SCAN_DIV    = 4,
  parameter int FETCH_GAP   = 16,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [4:0]  switch,
  input  logic [1:0]  byte_sel,
  output logic        rd_req,
  output logic [4:0]  rd_addr,
  input  logic        rd_ack,
  input  logic [31:0] rd_data,
  output logic [0:6]  seg,
  output logic [1:0]  anode
);

  localparam int SCW = $clog2(SCAN_DIV);
  localparam int GW  = $clog2(FETCH_GAP + 1);
  localparam int TW  = $clog2(ACK_TIMEOUT + 1);

  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
  localparam logic [GW-1:0]  GAP_LAST  = GW'(FETCH_GAP - 1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(ACK_TIMEOUT - 1);

  localparam logic [0:6] SEG_DASH  = 7'b1111110;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHOW,
    ERR
  } state_t;

  state_t         state;
  logic [1:0]     sel;
  logic [7:0]     disp_byte;
  logic           valid;
  logic [TW-1:0]  tmo_cnt;
  logic [GW-1:0]  gap_cnt;
  logic [SCW-1:0] scan_cnt;
  logic           digit;

  logic           chg;
  logic [7:0]     pick;
  logic [3:0]     nib;

  function automatic logic [0:6] hex7(
    input logic [3:0] n
  );
    logic [0:6] s;
    unique case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'ha: s = 7'b0001000;
      4'hb: s = 7'b1100000;
      4'hc: s = 7'b0110001;
      4'hd: s = 7'b1000010;
      4'he: s = 7'b0110000;
      4'hf: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign chg = (switch != rd_addr)
            || (byte_sel != sel);

  always_comb begin
    pick = rd_data[7:0];
    unique case (sel)
      2'd0: pick = rd_data[7:0];
      2'd1: pick = rd_data[15:8];
      2'd2: pick = rd_data[23:16];
      2'd3: pick = rd_data[31:24];
    endcase
  end

  assign nib = digit ? disp_byte[7:4]
                     : disp_byte[3:0];

  // Acknowledge is tested before the timeout so a late ack still lands.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      sel       <= '0;
      disp_byte <= '0;
      valid     <= 1'b0;
      tmo_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state   <= FETCH;
          rd_addr <= switch;
          sel     <= byte_sel;
          rd_req  <= 1'b1;
          tmo_cnt <= '0;
        end
        FETCH: begin
          if (rd_ack) begin
            disp_byte <= pick;
            valid     <= 1'b1;
            rd_req    <= 1'b0;
            gap_cnt   <= '0;
            state     <= SHOW;
          end else if (tmo_cnt == TMO_LAST) begin
            rd_req  <= 1'b0;
            gap_cnt <= '0;
            state   <= ERR;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        SHOW, ERR: begin
          if (chg || gap_cnt == GAP_LAST) begin
            state   <= FETCH;
            rd_addr <= switch;
            sel     <= byte_sel;
            rd_req  <= 1'b1;
            tmo_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      digit    <= 1'b0;
      anode    <= 2'b11;
      seg      <= SEG_BLANK;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        digit    <= ~digit;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      unique case (1'b1)
        (state == ERR): begin
          anode <= digit ? 2'b01 : 2'b10;
          seg   <= SEG_DASH;
        end
        (state != ERR && !valid): begin
          anode <= 2'b11;
          seg   <= SEG_BLANK;
        end
        (state != ERR && valid): begin
          anode <= digit ? 2'b01 : 2'b10;
          seg   <= hex7(nib);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: vector table, directed corner cases and a random run,
// all checked against a phase/cycle-count model of the controller.
`timescale 1ns/1ps

module tb_seg_scan_ctrl;

  localparam int SCAN_DIV    = 4;
  localparam int FETCH_GAP   = 16;
  localparam int ACK_TIMEOUT = 8;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [4:0]  switch;
  logic [1:0]  byte_sel;
  logic        rd_req;
  logic [4:0]  rd_addr;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic [0:6]  seg;
  logic [1:0]  anode;

  int total = 0;
  int pass  = 0;

  seg_scan_ctrl #(
    .SCAN_DIV(SCAN_DIV),
    .FETCH_GAP(FETCH_GAP),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .switch(switch),
    .byte_sel(byte_sel),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_ack(rd_ack),
    .rd_data(rd_data),
    .seg(seg),
    .anode(anode)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  typedef enum {P_IDLE, P_FETCH, P_SHOW, P_ERR} phase_t;

  phase_t     m_ph;
  logic [4:0] m_addr;
  logic [1:0] m_sel;
  logic [7:0] m_byte;
  bit         m_valid;
  int         m_n;
  int         m_t;

  function automatic logic [6:0] hexmap(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
          7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
          7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return t[n];
  endfunction

  function automatic logic [8:0] m_disp();
    int dig;
    logic [1:0] an;
    logic [3:0] nb;
    dig = (m_t / SCAN_DIV) % 2;
    an  = (dig == 1) ? 2'b01 : 2'b10;
    if (m_ph == P_ERR) return {an, 7'b1111110};
    if (!m_valid) return {2'b11, 7'b1111111};
    nb = (dig == 1) ? m_byte[7:4] : m_byte[3:0];
    return {an, hexmap(nb)};
  endfunction

  task automatic m_reset();
    m_ph = P_IDLE;
    m_addr = '0;
    m_sel = '0;
    m_byte = '0;
    m_valid = 0;
    m_n = 0;
    m_t = 0;
  endtask

  task automatic m_adv(input logic [4:0] sw, input logic [1:0] bs,
                       input logic ack, input logic [31:0] data);
    m_t++;
    case (m_ph)
      P_IDLE: begin
        m_ph = P_FETCH;
        m_addr = sw;
        m_sel = bs;
        m_n = 0;
      end
      P_FETCH: begin
        m_n++;
        if (ack) begin
          m_byte = 8'(data >> (8 * m_sel));
          m_valid = 1;
          m_ph = P_SHOW;
          m_n = 0;
        end else if (m_n == ACK_TIMEOUT) begin
          m_ph = P_ERR;
          m_n = 0;
        end
      end
      default: begin
        m_n++;
        if (sw != m_addr || bs != m_sel || m_n == FETCH_GAP) begin
          m_ph = P_FETCH;
          m_addr = sw;
          m_sel = bs;
          m_n = 0;
        end
      end
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    else
      pass++;
  endtask

  task automatic step();
    logic [8:0] ed;
    ed = m_disp();
    m_adv(switch, byte_sel, rd_ack, rd_data);
    @(posedge clk_in);
    #1;
    chk("model", {17'd0, rd_req, rd_addr, anode, seg},
        {17'd0, m_ph == P_FETCH, m_addr, ed});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rd_ack = 1'b0;
    @(posedge clk_in);
    #1;
    chk("reset", {17'd0, rd_req, rd_addr, anode, seg},
        {17'd0, 1'b0, 5'd0, 2'b11, 7'b1111111});
    m_reset();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [4:0]  sw;
    logic [1:0]  bs;
    logic [31:0] data;
    logic [6:0]  lo;
    logic [6:0]  hi;
  } vec_t;

  vec_t vt [8];

  initial begin
    logic [6:0]  got_lo;
    logic [6:0]  got_hi;
    logic [31:0] mask;
    int          p;

    vt[0] = '{5'd3,  2'd0, 32'h000000A3, 7'b0000110, 7'b0001000};
    vt[1] = '{5'd1,  2'd3, 32'hF1000000, 7'b1001111, 7'b0111000};
    vt[2] = '{5'd4,  2'd1, 32'h00005000, 7'b0000001, 7'b0100100};
    vt[3] = '{5'd6,  2'd2, 32'h00C80000, 7'b0000000, 7'b0110001};
    vt[4] = '{5'd8,  2'd0, 32'h000000E9, 7'b0000100, 7'b0110000};
    vt[5] = '{5'd10, 2'd2, 32'h00D70000, 7'b0001111, 7'b1000010};
    vt[6] = '{5'd12, 2'd3, 32'h2B000000, 7'b1100000, 7'b0010010};
    vt[7] = '{5'd31, 2'd1, 32'h00006400, 7'b1001100, 7'b0100000};

    rst = 1'b1;
    switch = '0;
    byte_sel = '0;
    rd_ack = 1'b0;
    rd_data = '0;
    m_reset();
    @(posedge clk_in);
    do_reset();

    // first fetch: ack on the second FETCH cycle
    switch = 5'd3;
    byte_sel = 2'd0;
    step();
    chk("first_req", {31'd0, rd_req}, 32'd1);
    chk("first_addr", {27'd0, rd_addr}, 32'd3);
    step();
    chk("req_hold", {31'd0, rd_req}, 32'd1);
    rd_ack = 1'b1;
    rd_data = 32'h000000A3;
    step();
    chk("req_drop", {31'd0, rd_req}, 32'd0);
    rd_ack = 1'b0;
    rd_data = $urandom;
    step();
    chk("scan_e4", {23'd0, anode, seg}, {23'd0, 2'b10, 7'b0000110});
    for (int k = 5; k <= 12; k++) begin
      step();
      if (k <= 8)
        chk("scan_hi", {23'd0, anode, seg}, {23'd0, 2'b01, 7'b0001000});
      else
        chk("scan_lo", {23'd0, anode, seg}, {23'd0, 2'b10, 7'b0000110});
    end

    // switch change in SHOW, old byte stays up during the refetch
    switch = 5'd5;
    step();
    chk("chg_req", {31'd0, rd_req}, 32'd1);
    chk("chg_addr", {27'd0, rd_addr}, 32'd5);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("keep_old", {31'd0, seg == 7'b0000110 || seg == 7'b0001000}, 32'd1);
    end
    rd_ack = 1'b1;
    rd_data = 32'h00000077;
    step();
    rd_ack = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("new_byte", {25'd0, seg}, {25'd0, 7'b0001111});

    // no ack: timeout, dash, retry
    do_reset();
    switch = 5'd7;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("to_req_hi", {31'd0, rd_req}, 32'd1);
    end
    step();
    chk("to_req_lo", {31'd0, rd_req}, 32'd0);
    for (int k = 0; k < 16; k++) begin
      step();
      chk("err_dash", {25'd0, seg}, {25'd0, 7'b1111110});
      chk("err_retry", {31'd0, rd_req}, {31'd0, k == 15});
    end

    // ack coincides with the timeout cycle
    do_reset();
    switch = 5'd2;
    byte_sel = 2'd1;
    step();
    for (int k = 0; k < 7; k++) step();
    rd_ack = 1'b1;
    rd_data = 32'h12345A00;
    step();
    rd_ack = 1'b0;
    chk("race_req", {31'd0, rd_req}, 32'd0);
    step();
    chk("race_show", {23'd0, anode, seg}, {23'd0, 2'b10, 7'b0001000});

    // asynchronous reset during FETCH
    do_reset();
    switch = 5'd9;
    step();
    chk("pre_rst_req", {31'd0, rd_req}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst", {28'd0, rd_req, anode, seg[6]}, {28'd0, 1'b0, 2'b11, 1'b1});
    @(posedge clk_in);
    #1;
    m_reset();
    rst = 1'b0;
    switch = 5'd12;
    step();
    chk("restart", {26'd0, rd_req, rd_addr}, {26'd0, 1'b1, 5'd12});

    // vector table
    for (int v = 0; v < 8; v++) begin
      do_reset();
      switch = vt[v].sw;
      byte_sel = vt[v].bs;
      step();
      mask = 32'hFF << (8 * vt[v].bs);
      rd_ack = 1'b1;
      rd_data = vt[v].data | ($urandom & ~mask);
      step();
      rd_ack = 1'b0;
      got_lo = '1;
      got_hi = '1;
      for (int k = 0; k < 8; k++) begin
        step();
        if (anode == 2'b10) got_lo = seg;
        if (anode == 2'b01) got_hi = seg;
      end
      chk($sformatf("vec%0d_lo", v), {25'd0, got_lo}, {25'd0, vt[v].lo});
      chk($sformatf("vec%0d_hi", v), {25'd0, got_hi}, {25'd0, vt[v].hi});
    end

    // random run
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) p = $urandom_range(5, 60);
      rd_ack = ($urandom_range(0, 99) < p);
      rd_data = $urandom;
      if ($urandom_range(0, 24) == 0) switch = 5'($urandom);
      if ($urandom_range(0, 39) == 0) byte_sel = 2'($urandom);
      if ($urandom_range(0, 799) == 0) do_reset();
      else step();
    end

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
